// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment display: digit count,
// the all-off select code and the digit-to-anode encoding used by seg_scan and seg_mux.
package seg_pkg;

    localparam int N_DIGITS = 4;
    localparam int IDX_W    = $clog2(N_DIGITS);

    localparam logic [N_DIGITS-1:0] SEL_OFF = '1;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    // Active-low one-cold anode select for a digit index.
    function automatic logic [N_DIGITS-1:0] digit_sel(input logic [IDX_W-1:0] idx);
        return ~(N_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/seg_prescale.sv
// Digit-slot prescaler: counts 0..REFRESH_DIV-1 while enabled and strobes on the
// last count of each slot. The count freezes when the enable is low.
module seg_prescale #(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             wrap_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // NOTE: flops use non-blocking (<=) so every register samples pre-edge values;
    // blocking here would create order-dependent races between always_ff blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/seg_scan.sv
// Anode scan driver: time-slices four digits with leading dead-time per slot,
// per-digit masking and a once-per-frame tick. All outputs are registered.
module seg_scan
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [N_DIGITS-1:0] digit_mask,
    output logic [N_DIGITS-1:0] sel,
    output logic [IDX_W-1:0]    dig_idx,
    output logic                blank,
    output logic                frame_tick
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    if (REFRESH_DIV < 2 || BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_param
        $fatal(1, "seg_scan: illegal REFRESH_DIV=%0d / BLANK_CYCLES=%0d", REFRESH_DIV, BLANK_CYCLES);
    end

    localparam scan_state_e      RESET_STATE = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;
    localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_DIGIT  = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]    cnt;
    logic                wrap;
    scan_state_e         state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [N_DIGITS-1:0] sel_q, sel_d;
    logic [IDX_W-1:0]    dig_idx_q;
    logic                blank_q, blank_d;
    logic                frame_tick_q, frame_tick_d;

    seg_prescale #(
        .REFRESH_DIV (REFRESH_DIV),
        .CNT_W       (CNT_W)
    ) u_prescale (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en),
        .cnt_o  (cnt),
        .wrap_o (wrap)
    );

    // NOTE: every signal gets a default before any branch so always_comb never infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BLANK: if (en && cnt == BLANK_LAST)     state_d = ST_DRIVE;
            ST_DRIVE: if (wrap && BLANK_CYCLES > 0)    state_d = ST_BLANK;
            default:                                   state_d = RESET_STATE;
        endcase

        idx_d = wrap ? idx_q + IDX_W'(1) : idx_q;

        sel_d = digit_sel(idx_q);
        if (!en || state_q == ST_BLANK || digit_mask[idx_q]) begin
            sel_d = SEL_OFF;
        end
        blank_d      = (sel_d == SEL_OFF);
        frame_tick_d = wrap && (idx_q == LAST_DIGIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RESET_STATE;
            idx_q        <= '0;
            sel_q        <= SEL_OFF;
            dig_idx_q    <= '0;
            blank_q      <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            sel_q        <= sel_d;
            dig_idx_q    <= idx_q;
            blank_q      <= blank_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign sel        = sel_q;
    assign dig_idx    = dig_idx_q;
    assign blank      = blank_q;
    assign frame_tick = frame_tick_q;

endmodule
